// File: rtl/hilo_muldiv_seq.sv
// Sequential HI/LO multiply/divide unit: one bit per cycle, commits results into HI/LO.
// Optional macro MULDIV_EARLY_OUT_EN stops multiplies once the remaining multiplier bits are zero.
module hilo_muldiv_seq #(
    parameter logic [31:0] DIV0_QUO = 32'hFFFF_FFFF,
    parameter logic [31:0] DIV0_REM = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        is_signed_q, is_signed_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic        div0_q, div0_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        accept;
    logic        signed_op;
    logic        a_neg, b_neg;
    logic [31:0] a_abs, b_abs;
    logic        last_iter;
    logic [63:0] mul_sum;
    logic [32:0] rem_sh;
    logic [32:0] div_diff;
    logic [31:0] quo_fix, rem_fix;
    logic [63:0] prod_fix;

    assign accept    = (state_q == IDLE) && start && !flush;
    assign signed_op = ~op[2] & op[0];
    assign a_neg     = signed_op & a[31];
    assign b_neg     = signed_op & b[31];
    assign a_abs     = a_neg ? (~a + 32'd1) : a;
    assign b_abs     = b_neg ? (~b + 32'd1) : b;

    // Multiplier shifts right each iteration, so an all-zero tail means the product is final.
    always_comb begin
        last_iter = (cnt_q == 6'd31);
`ifdef MULDIV_EARLY_OUT_EN
        if (!is_div_q && (opb_q[31:1] == 31'd0)) begin
            last_iter = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && !op[2]) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (last_iter) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

    assign mul_sum  = acc_q + (opb_q[0] ? opa_q : 64'd0);
    assign rem_sh   = {acc_q[63:32], acc_q[31]};
    assign div_diff = rem_sh - {1'b0, opa_q[31:0]};

    assign quo_fix  = (is_signed_q && (sa_q ^ sb_q)) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    assign rem_fix  = (is_signed_q && sa_q) ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    assign prod_fix = (is_signed_q && (sa_q ^ sb_q)) ? (~acc_q + 64'd1) : acc_q;

    // Divide keeps {remainder, quotient} in acc; multiply accumulates the shifted multiplicand into acc.
    always_comb begin
        cnt_d       = cnt_q;
        is_div_d    = is_div_q;
        is_signed_d = is_signed_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        div0_d      = div0_q;
        acc_d       = acc_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end else if (!op[2]) begin
                        is_div_d    = op[1];
                        is_signed_d = op[0];
                        sa_d        = a_neg;
                        sb_d        = b_neg;
                        div0_d      = (b == 32'd0);
                        cnt_d       = 6'd0;
                        if (op[1]) begin
                            acc_d = {32'd0, a_abs};
                            opa_d = {32'd0, b_abs};
                            opb_d = 32'd0;
                        end else begin
                            acc_d = 64'd0;
                            opa_d = {32'd0, a_abs};
                            opb_d = b_abs;
                        end
                    end
                end
            end
            RUN: begin
                if (!flush) begin
                    cnt_d = cnt_q + 6'd1;
                    if (is_div_q) begin
                        if (!div_diff[32]) begin
                            acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
                        end else begin
                            acc_d = {rem_sh[31:0], acc_q[30:0], 1'b0};
                        end
                    end else begin
                        acc_d = mul_sum;
                        opa_d = {opa_q[62:0], 1'b0};
                        opb_d = {1'b0, opb_q[31:1]};
                    end
                end
            end
            FIX: begin
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q && div0_q) begin
                        hi_d = DIV0_REM;
                        lo_d = DIV0_QUO;
                    end else if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end
                end
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= 6'd0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            div0_q      <= 1'b0;
            acc_q       <= 64'd0;
            opa_q       <= 64'd0;
            opb_q       <= 32'd0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            done_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            is_div_q    <= is_div_d;
            is_signed_q <= is_signed_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            div0_q      <= div0_d;
            acc_q       <= acc_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: doc/hilo_muldiv_seq.md
Name: hilo_muldiv_seq

Overview:
- Multi-cycle, register-owning counterpart to the single-cycle combinational ALU mul/div path.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the EX stage over a start/busy/done handshake.
- Iterates one bit per cycle and commits results into the architectural HI/LO registers.
- HI/LO are continuously visible for MFHI/MFLO; the pipeline stalls on busy.

Parameters:
- DIV0_QUO, 32'hFFFF_FFFF, quotient (LO) written on divide by zero.
- DIV0_REM, 32'hDEAD_BEEF, remainder (HI) written on divide by zero.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request valid; sampled only when busy=0.
- op  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO; 110/111 are no-ops.
- a  in  32  rs operand (dividend / multiplicand / MTHI/MTLO data).
- b  in  32  rt operand (divisor / multiplier).
- flush  in  1  abort any in-flight operation.
- busy  out  1  operation in flight; start ignored while high.
- done  out  1  one-cycle pulse; HI/LO updated by a mul/div.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, hi=0, lo=0. All internal accumulators and counters are cleared.
- States:
  - IDLE: accepts start.
  - RUN: one iteration per cycle; 6-bit counter.
  - FIX: sign correction and HI/LO write.
- Accept edge E0 (IDLE, start=1):
  - MTHI: hi<=a. MTLO: lo<=a. State stays IDLE; busy stays 0; no done pulse.
  - Mul/div ops: latch a, b and op. For signed ops, latch the absolute values plus the sign bits. Go to RUN; busy=1 from E0.
  - op 110/111: ignored.
- RUN:
  - Multiply: shift-add, 64-bit product over 32 iterations (edges E1..E32).
  - Divide: restoring shift-subtract, 32 iterations (edges E1..E32).
  - After the last iteration go to FIX.
- FIX (edge E33):
  - Signed MULT: 64-bit product negated when sa^sb.
  - Signed DIV: quotient negated when sa^sb; remainder negated when sa.
  - Write {hi,lo}: product = {upper,lower}; divide = {remainder,quotient}.
  - Go to IDLE with busy=0 and done=1 for exactly the cycle E33..E34.
  - Total latency: accept edge to result edge = 33 cycles.
- Divide by zero (b==0, signed or unsigned):
  - Same 33-cycle latency.
  - FIX writes hi=DIV0_REM, lo=DIV0_QUO, no sign correction.
- DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0. No trap, no flag.
- start while busy=1: ignored, no queueing.
- start in the done cycle: state is IDLE, so it is accepted (back-to-back).
- flush:
  - In RUN/FIX: return to IDLE at the next edge; hi/lo unchanged; no done.
  - In IDLE: ignored.
  - Same edge as start in IDLE: flush wins, request dropped (including MTHI/MTLO).
- hi/lo change only at:
  - FIX commit
  - MTHI/MTLO accept
  - reset

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - MULT/MULTU run k = max(1, msb_index(|b|)+1) iterations, then FIX.
  - Latency = k+1 cycles (b=0 → 2 cycles; b=3 → 3 cycles).
  - Results are bit-identical to full length.
  - DIV/DIVU are unaffected.
- Undefined: every multiply takes 33 cycles; no early-out logic is synthesized.

Test Plan:
- MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF → 33 cycles later done=1; hi=0xFFFF_FFFE, lo=0x0000_0001; busy=1 for exactly 33 cycles.
- MULT a=-7 (0xFFFF_FFF9), b=6 → hi=0xFFFF_FFFF, lo=0xFFFF_FFD6. DIV a=-7, b=2 → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
- DIVU a=100, b=0 → hi=0xDEAD_BEEF, lo=0xFFFF_FFFF, done after 33 cycles. DIV a=0x8000_0000, b=0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- MTHI a=0x1234_5678 in IDLE → hi updates next edge, busy/done stay 0.
- MTLO issued while busy → lo unchanged, request not queued.
- DIVU 10/3 with flush at cycle 10 → busy=0 next cycle, no done, hi/lo keep prior values. New start same cycle as done → accepted, second done 33 cycles later.
- Assert rst mid-RUN (asynchronously, between edges) → busy, done, hi, lo = 0 immediately. With MULDIV_EARLY_OUT_EN: MULTU a=5, b=3 → done 3 cycles after accept, lo=15, hi=0.
